// File: rtl/camera_pixel_capture.sv
`default_nettype none
// ============================================================================
//  Module   : camera_pixel_capture
//  Purpose  : Samples the OV7670 RGB565 byte stream (two bytes per pixel),
//             packs each pixel to RGB332 and generates X/Y addresses plus a
//             one-cycle write strobe for the dual-port frame buffer. Reports
//             frame completion and geometry overflow.
//  Options  : CAPTURE_TEST_PATTERN_EN - replace camera pixels with a
//             red/blue/white vertical bar pattern (timing unchanged).
//  Revision : 1.0 - initial release
// ============================================================================
module camera_pixel_capture #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       VSYNC,
  input  logic       HREF,
  input  logic [7:0] CAM_DATA,
  output logic [7:0] PIXEL_OUT,
  output logic [9:0] X_ADDR,
  output logic [9:0] Y_ADDR,
  output logic       W_EN,
  output logic       FRAME_DONE,
  output logic       OVERFLOW
);

  localparam logic [9:0] c_width  = 10'(SCREEN_WIDTH);
  localparam logic [9:0] c_height = 10'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    VBLANK     = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_frame_end;

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_phase;
  logic [5:0]  r_byte1;     // {R[4:2], G[5:3]} of the first byte
  logic        r_href_d;
  logic        r_line_px;   // current line completed at least one pixel
  logic        r_frame_px;  // current frame wrote at least one pixel

  logic [7:0]  r_pixel;
  logic [9:0]  r_x_addr;
  logic [9:0]  r_y_addr;
  logic        r_w_en;
  logic        r_frame_done;
  logic        r_overflow;

  logic        w_line_end;
  logic        w_x_ok;
  logic        w_y_ok;
  logic [9:0]  w_x_inc;
  logic [9:0]  w_y_inc;
  logic [7:0]  w_pixel;

  assign w_line_end = r_href_d & ~HREF;
  assign w_x_ok     = (r_x < c_width);
  assign w_y_ok     = (r_y < c_height);
  // Counters saturate at the screen limit so they can never wrap back
  // into the visible area on oversized input.
  assign w_x_inc    = w_x_ok ? (r_x + 10'd1) : c_width;
  assign w_y_inc    = w_y_ok ? (r_y + 10'd1) : c_height;

`ifdef CAPTURE_TEST_PATTERN_EN
  // Bars compare 3*X against the width so the thirds split exactly even
  // when the width is not divisible by three.
  logic [11:0] w_x3;
  assign w_x3 = {2'b00, r_x} * 12'd3;

  // Vertical bar pattern selected by the current column.
  always_comb begin
    w_pixel = 8'hFF;
    if (w_x3 < 12'(SCREEN_WIDTH)) begin
      w_pixel = 8'hE0;
    end else if (w_x3 < 12'(2 * SCREEN_WIDTH)) begin
      w_pixel = 8'h03;
    end
  end
`else
  // RGB565 -> RGB332: keep the top bits of each colour channel.
  assign w_pixel = {r_byte1[5:3], r_byte1[2:0], CAM_DATA[4:3]};
`endif

  // Frame state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= WAIT_FRAME;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; flags the end of a frame that wrote pixels.
  always_comb begin
    w_state_next = r_state;
    w_frame_end  = 1'b0;
    case (r_state)
      WAIT_FRAME: if (VSYNC) w_state_next = VBLANK;
      VBLANK:     if (!VSYNC) w_state_next = ACTIVE;
      ACTIVE: begin
        if (VSYNC) begin
          w_state_next = VBLANK;
          w_frame_end  = r_frame_px;
        end
      end
      default:    w_state_next = WAIT_FRAME;
    endcase
  end

  // Byte pairing, address counters, write strobe and status flags.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_phase      <= 1'b0;
      r_byte1      <= 6'd0;
      r_href_d     <= 1'b0;
      r_line_px    <= 1'b0;
      r_frame_px   <= 1'b0;
      r_pixel      <= 8'd0;
      r_x_addr     <= 10'd0;
      r_y_addr     <= 10'd0;
      r_w_en       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_w_en       <= 1'b0;
      r_frame_done <= w_frame_end;
      r_href_d     <= HREF;
      case (r_state)
        VBLANK: begin
          r_x        <= 10'd0;
          r_y        <= 10'd0;
          r_phase    <= 1'b0;
          r_line_px  <= 1'b0;
          r_frame_px <= 1'b0;
          r_overflow <= 1'b0;
        end
        ACTIVE: begin
          // Bytes arriving alongside a rising VSYNC belong to blanking.
          if (!VSYNC) begin
            if (HREF) begin
              if (!r_phase) begin
                r_byte1 <= {CAM_DATA[7:5], CAM_DATA[2:0]};
                r_phase <= 1'b1;
              end else begin
                r_phase   <= 1'b0;
                r_line_px <= 1'b1;
                r_x       <= w_x_inc;
                if (w_x_ok && w_y_ok) begin
                  r_w_en     <= 1'b1;
                  r_pixel    <= w_pixel;
                  r_x_addr   <= r_x;
                  r_y_addr   <= r_y;
                  r_frame_px <= 1'b1;
                end else begin
                  r_overflow <= 1'b1;
                end
              end
            end else if (w_line_end) begin
              // An odd trailing byte is dropped by forcing phase 0.
              r_phase   <= 1'b0;
              r_x       <= 10'd0;
              r_line_px <= 1'b0;
              if (r_line_px) begin
                r_y <= w_y_inc;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign PIXEL_OUT  = r_pixel;
  assign X_ADDR     = r_x_addr;
  assign Y_ADDR     = r_y_addr;
  assign W_EN       = r_w_en;
  assign FRAME_DONE = r_frame_done;
  assign OVERFLOW   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_camera_pixel_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_camera_pixel_capture
//  Purpose  : Self-checking bench for camera_pixel_capture. Expected writes
//             are queued as bytes are driven and matched against W_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_camera_pixel_capture;

  localparam int W = 176;
  localparam int H = 144;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] CAM_DATA;
  logic [7:0] PIXEL_OUT;
  logic [9:0] X_ADDR;
  logic [9:0] Y_ADDR;
  logic       W_EN;
  logic       FRAME_DONE;
  logic       OVERFLOW;

  camera_pixel_capture #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .VSYNC(VSYNC), .HREF(HREF),
    .CAM_DATA(CAM_DATA), .PIXEL_OUT(PIXEL_OUT), .X_ADDR(X_ADDR),
    .Y_ADDR(Y_ADDR), .W_EN(W_EN), .FRAME_DONE(FRAME_DONE),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] p;
    logic [9:0] x;
    logic [9:0] y;
    int         c;
  } exp_t;

  exp_t       q[$];
  logic [7:0] lb[$];
  int         cnt = 0;
  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         fd_cnt = 0;
  int         fd_cyc = -1;

  always @(posedge CLK) cnt++;

  // Scoreboard: every W_EN must match the oldest queued write and its cycle.
  always @(negedge CLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].c < cnt) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_write x=%0d y=%0d expected_cycle=%0d now=%0d", e.x, e.y, e.c, cnt);
    end
    if (W_EN === 1'b1) begin
      wr_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write pix=%h x=%0d y=%0d cycle=%0d", PIXEL_OUT, X_ADDR, Y_ADDR, cnt);
      end else begin
        e = q.pop_front();
        if (PIXEL_OUT !== e.p || X_ADDR !== e.x || Y_ADDR !== e.y || cnt !== e.c) begin
          errors++;
          $display("FAIL write got pix=%h x=%0d y=%0d cyc=%0d exp pix=%h x=%0d y=%0d cyc=%0d",
                   PIXEL_OUT, X_ADDR, Y_ADDR, cnt, e.p, e.x, e.y, e.c);
        end
      end
    end
    if (FRAME_DONE === 1'b1) begin
      fd_cnt++;
      fd_cyc = cnt;
    end
  end

  function automatic logic [7:0] exp_pix(input logic [7:0] b1, input logic [7:0] b2, input int x);
`ifdef CAPTURE_TEST_PATTERN_EN
    if (3 * x < W) return 8'hE0;
    if (3 * x < 2 * W) return 8'h03;
    return 8'hFF;
`else
    return {b1[7:5], b1[2:0], b2[4:3]};
`endif
  endfunction

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge CLK);
    #1;
    VSYNC    = vs;
    HREF     = hr;
    CAM_DATA = d;
  endtask

  // Drives lb as one line, queueing writes that fall inside the screen.
  task automatic send_line(input int y);
    for (int i = 0; i < lb.size(); i++) begin
      drive(1'b0, 1'b1, lb[i]);
      if (i % 2 == 1) begin
        int   x;
        exp_t e;
        x = i / 2;
        if (x < W && y < H) begin
          e.p = exp_pix(lb[i-1], lb[i], x);
          e.x = 10'(x);
          e.y = 10'(y);
          e.c = cnt + 1;
          q.push_back(e);
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic fill_pairs(input int npix, input logic [7:0] b1, input logic [7:0] b2);
    lb.delete();
    for (int i = 0; i < npix; i++) begin
      lb.push_back(b1);
      lb.push_back(b2);
    end
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame(input int exp_fd);
    int fd0;
    int k;
    fd0 = fd_cnt;
    drive(1'b1, 1'b0, 8'h00);
    k = cnt;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (fd_cnt !== fd0 + exp_fd) begin
      errors++;
      $display("FAIL frame_done_count got=%0d exp=%0d", fd_cnt - fd0, exp_fd);
    end
    if (exp_fd == 1) begin
      checks++;
      if (fd_cyc !== k + 1) begin
        errors++;
        $display("FAIL frame_done_cycle got=%0d exp=%0d", fd_cyc, k + 1);
      end
    end
  endtask

  task automatic test_reset();
    RESET_N  = 1'b0;
    VSYNC    = 1'b0;
    HREF     = 1'b0;
    CAM_DATA = 8'h00;
    #3;
    checks++;
    if ({PIXEL_OUT, X_ADDR, Y_ADDR, W_EN, FRAME_DONE, OVERFLOW} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs got pix=%h x=%0d y=%0d wen=%b fd=%b ovf=%b exp all 0",
               PIXEL_OUT, X_ADDR, Y_ADDR, W_EN, FRAME_DONE, OVERFLOW);
    end
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // Capture must not start until a full vertical blank has been seen.
  task automatic test_wait_frame();
    int w0;
    w0 = wr_cnt;
    fill_pairs(4, 8'h07, 8'hE0);
    for (int i = 0; i < lb.size(); i++) drive(1'b0, 1'b1, lb[i]);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL wait_frame_writes got=%0d exp=0", wr_cnt - w0);
    end
  endtask

  task automatic test_first_line();
    start_frame();
    lb = {8'hF8, 8'h00, 8'h00, 8'h1F};
    send_line(0);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (PIXEL_OUT !== exp_pix(8'h00, 8'h1F, 1) || X_ADDR !== 10'd1 || Y_ADDR !== 10'd0 || W_EN !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_line got pix=%h x=%0d y=%0d wen=%b exp pix=%h x=1 y=0 wen=0",
               PIXEL_OUT, X_ADDR, Y_ADDR, W_EN, exp_pix(8'h00, 8'h1F, 1));
    end
    end_frame(1);
  endtask

  task automatic test_full_frame();
    int w0;
    w0 = wr_cnt;
    start_frame();
    fill_pairs(W, 8'h07, 8'hE0);
    for (int y = 0; y < H; y++) send_line(y);
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL full_frame_overflow got=%b exp=0", OVERFLOW);
    end
    checks++;
    if (wr_cnt - w0 !== W * H) begin
      errors++;
      $display("FAIL full_frame_writes got=%0d exp=%0d", wr_cnt - w0, W * H);
    end
    end_frame(1);
  endtask

  task automatic test_overflow();
    start_frame();
    lb.delete();
    for (int i = 0; i < 180; i++) begin
      lb.push_back(8'((i * 37) & 8'hFF));
      lb.push_back(8'((i * 11 + 5) & 8'hFF));
    end
    send_line(0);
    checks++;
    if (OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL long_line_overflow got=%b exp=1", OVERFLOW);
    end
    lb = {8'hF8, 8'h1F};
    for (int y = 1; y < 146; y++) send_line(y);
    end_frame(1);
    checks++;
    if (OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear_vblank got=%b exp=0", OVERFLOW);
    end
  endtask

  // One extra line beyond the screen height must raise OVERFLOW by itself.
  task automatic test_y_overflow();
    start_frame();
    lb = {8'h07, 8'hE0};
    for (int y = 0; y < H; y++) send_line(y);
    checks++;
    if (OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL y_limit_no_overflow got=%b exp=0", OVERFLOW);
    end
    send_line(H);
    checks++;
    if (OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL y_overflow got=%b exp=1", OVERFLOW);
    end
    send_line(H + 1);
    end_frame(1);
  endtask

  task automatic test_odd_line();
    start_frame();
    lb = {8'hF8, 8'h1F, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hAA};
    send_line(0);
    lb = {8'h5A, 8'hC3};
    send_line(1);
    drive(1'b0, 1'b0, 8'h00);
    end_frame(1);
  endtask

  task automatic test_reset_midline();
    int w0;
    start_frame();
    fill_pairs(50, 8'hE7, 8'h18);
    for (int i = 0; i < lb.size(); i++) begin
      drive(1'b0, 1'b1, lb[i]);
      if (i % 2 == 1) begin
        exp_t e;
        e.p = exp_pix(lb[i-1], lb[i], i / 2);
        e.x = 10'(i / 2);
        e.y = 10'd0;
        e.c = cnt + 1;
        q.push_back(e);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({PIXEL_OUT, X_ADDR, Y_ADDR, W_EN, FRAME_DONE, OVERFLOW} !== 31'd0) begin
      errors++;
      $display("FAIL async_reset_outputs got pix=%h x=%0d y=%0d wen=%b fd=%b ovf=%b exp all 0",
               PIXEL_OUT, X_ADDR, Y_ADDR, W_EN, FRAME_DONE, OVERFLOW);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    w0 = wr_cnt;
    fill_pairs(8, 8'h07, 8'hE0);
    for (int i = 0; i < lb.size(); i++) drive(1'b0, 1'b1, lb[i]);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL post_reset_writes got=%0d exp=0", wr_cnt - w0);
    end
    start_frame();
    lb = {8'hF8, 8'h00, 8'h00, 8'h1F};
    send_line(0);
    end_frame(1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout cycle=%0d", cnt);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_wait_frame();
    test_first_line();
    test_full_frame();
    test_overflow();
    test_y_overflow();
    test_odd_line();
    test_reset_midline();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL pending_writes got=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
